// File: rtl/full_adder_8b_pkg.sv
// Shared ALU definitions: datapath width and the registered flag bundle
// produced alongside each adder result.
package full_adder_8b_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } alu_flags_t;

endpackage : full_adder_8b_pkg

// File: rtl/full_adder_8b_if.sv
// Operand/result bundle between the ALU control path (master) and the
// registered adder (slave).
interface full_adder_8b_if
  import full_adder_8b_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             out_valid;

  modport master (
    output a, b, carry_in, in_valid,
    input  sum, carry_out, overflow, zero, out_valid
  );

  modport slave (
    input  a, b, carry_in, in_valid,
    output sum, carry_out, overflow, zero, out_valid
  );

endinterface : full_adder_8b_if

// File: rtl/full_adder_1b.sv
// Single-bit full adder cell; chained by full_adder_8b into a ripple carry.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder_1b

// File: rtl/full_adder_8b.sv
// Registered ripple-carry adder: one-cycle latency from operands to
// sum, carry-out, signed overflow and zero flags, plus a valid shadow.
module full_adder_8b
  import full_adder_8b_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  full_adder_8b_if.slave bus
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  alu_flags_t       flags_d;
  alu_flags_t       flags_q;
  logic             valid_q;

  assign c[0] = bus.carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_1b u_fa (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .cin  (c[i]),
      .s    (sum_d[i]),
      .cout (c[i+1])
    );
  end : g_bit

  // Overflow is taken from the ripple chain itself: carry into MSB vs carry out.
  always_comb begin
    flags_d          = '0;
    flags_d.carry    = c[WIDTH];
    flags_d.overflow = c[WIDTH-1] ^ c[WIDTH];
    flags_d.zero     = (sum_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      flags_q <= flags_d;
      valid_q <= bus.in_valid;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry_out = flags_q.carry;
  assign bus.overflow  = flags_q.overflow;
  assign bus.zero      = flags_q.zero;
  assign bus.out_valid = valid_q;

endmodule : full_adder_8b

// File: tb/tb_full_adder_8b.sv
// Self-checking bench for full_adder_8b: reset, corners, valid pipeline
// and random operands against an arithmetic reference model.
module tb_full_adder_8b;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  full_adder_8b_if #(.WIDTH(8)) bus ();

  full_adder_8b #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  function automatic exp_t ref_model(input logic [7:0] a, input logic [7:0] b,
                                     input logic cin);
    exp_t       e;
    logic [8:0] full;
    full   = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    e.sum  = full[7:0];
    e.cout = full[8];
    // signed overflow: like-signed operands giving a differently-signed result
    e.ovf  = (a[7] == b[7]) && (full[7] != a[7]);
    e.zero = (full[7:0] == 8'd0);
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, ".sum"},  {24'd0, bus.sum},   32'd0);
    cmp({tag, ".cout"}, {31'd0, bus.carry_out}, 32'd0);
    cmp({tag, ".ovf"},  {31'd0, bus.overflow},  32'd0);
    cmp({tag, ".zero"}, {31'd0, bus.zero},      32'd0);
    cmp({tag, ".vld"},  {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic vin);
    bus.a        = a;
    bus.b        = b;
    bus.carry_in = cin;
    bus.in_valid = vin;
  endtask

  // Apply operands at the falling edge, check one rising edge later.
  task automatic apply_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic cin, input logic vin);
    exp_t e;
    @(negedge clk);
    drive(a, b, cin, vin);
    e = ref_model(a, b, cin);
    @(posedge clk);
    #1;
    cmp({tag, ".sum"},  {24'd0, bus.sum},       {24'd0, e.sum});
    cmp({tag, ".cout"}, {31'd0, bus.carry_out}, {31'd0, e.cout});
    cmp({tag, ".ovf"},  {31'd0, bus.overflow},  {31'd0, e.ovf});
    cmp({tag, ".zero"}, {31'd0, bus.zero},      {31'd0, e.zero});
    cmp({tag, ".vld"},  {31'd0, bus.out_valid}, {31'd0, vin});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(8'h00, 8'h00, 1'b0, 1'b0);

    // Reset held with random inputs toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end

    @(negedge clk);
    rst_n = 1'b1;
    apply_check("rst_release", 8'h3C, 8'h42, 1'b1, 1'b1);

    // Corners
    apply_check("c_00_00_0", 8'h00, 8'h00, 1'b0, 1'b1);
    apply_check("c_FF_00_0", 8'hFF, 8'h00, 1'b0, 1'b1);
    apply_check("c_FF_00_1", 8'hFF, 8'h00, 1'b1, 1'b1);
    apply_check("c_FF_FF_0", 8'hFF, 8'hFF, 1'b0, 1'b1);
    apply_check("c_FF_FF_1", 8'hFF, 8'hFF, 1'b1, 1'b1);
    apply_check("ovf_7F_01", 8'h7F, 8'h01, 1'b0, 1'b1);
    apply_check("ovf_80_80", 8'h80, 8'h80, 1'b0, 1'b1);
    apply_check("rip_7F_00_1", 8'h7F, 8'h00, 1'b1, 1'b1);
    apply_check("rip_0F_F1", 8'h0F, 8'hF1, 1'b0, 1'b1);

    // Capture happens regardless of in_valid; valid pulse is one cycle wide
    apply_check("vld_idle", 8'h12, 8'h34, 1'b0, 1'b0);
    apply_check("vld_pulse", 8'hA5, 8'h5A, 1'b1, 1'b1);
    apply_check("vld_after", 8'h01, 8'h02, 1'b0, 1'b0);
    apply_check("vld_after2", 8'h80, 8'h7F, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle discards the registered result
    apply_check("pre_async", 8'hFF, 8'hFF, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    check_zero("async_hold");
    @(negedge clk);
    rst_n = 1'b1;
    apply_check("post_async", 8'h80, 8'h80, 1'b1, 1'b1);

    // Random operands and valid
    for (int i = 0; i < 10000; i++) begin
      apply_check("rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_full_adder_8b
